// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the write-back port sequencer.
package wb_seq_pkg;

  // Default widths for the GPR and CRF write ports.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_GPR_AW = 5;
  localparam int DEF_CRF_AW = 4;

  // GPR index that is hardwired to zero; writes to it are dropped.
  localparam int GPR_ZERO = 0;

  // IDLE accepts a new op every cycle; PEND2 issues the second half of a split pair write.
  typedef enum logic {
    IDLE  = 1'b0,
    PEND2 = 1'b1
  } wb_seq_state_t;

endpackage

// File: rtl/wb_port_sequencer_if.sv
// MEM/WB-side handshake plus the registered GPR/CRF write ports.
//
// Handshake: an op transfers on a rising edge where in_valid & in_ready are both 1.
// in_ready depends only on sequencer state, never on in_valid; the producer must hold
// all op fields stable while in_valid=1 and in_ready=0.
interface wb_port_sequencer_if
  import wb_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GPR_AW = DEF_GPR_AW,
  parameter int CRF_AW = DEF_CRF_AW
) ();

  logic              in_valid;
  logic              in_ready;
  logic              gpr_we_in;
  logic [GPR_AW-1:0] gpr_addr_in;
  logic [DATA_W-1:0] gpr_data_in;
  logic              crf_we_in;
  logic              crf_pair_in;
  logic [CRF_AW-1:0] crf_addr1_in;
  logic [CRF_AW-1:0] crf_addr2_in;
  logic [DATA_W-1:0] crf_data1_in;
  logic [DATA_W-1:0] crf_data2_in;

  logic              gpr_we;
  logic [GPR_AW-1:0] gpr_waddr;
  logic [DATA_W-1:0] gpr_wdata;
  logic              crf_we;
  logic [CRF_AW-1:0] crf_waddr;
  logic [DATA_W-1:0] crf_wdata;

  // Pipeline side: drives ops, observes ready and the write ports.
  modport master (
    output in_valid, gpr_we_in, gpr_addr_in, gpr_data_in,
           crf_we_in, crf_pair_in, crf_addr1_in, crf_addr2_in, crf_data1_in, crf_data2_in,
    input  in_ready, gpr_we, gpr_waddr, gpr_wdata, crf_we, crf_waddr, crf_wdata
  );

  // Sequencer side.
  modport slave (
    input  in_valid, gpr_we_in, gpr_addr_in, gpr_data_in,
           crf_we_in, crf_pair_in, crf_addr1_in, crf_addr2_in, crf_data1_in, crf_data2_in,
    output in_ready, gpr_we, gpr_waddr, gpr_wdata, crf_we, crf_waddr, crf_wdata
  );

endinterface

// File: rtl/wb_seq_perf_cnt.sv
// Saturating 32-bit event counter with synchronous clear.
module wb_seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        clear_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_port_sequencer.sv
// Write-back port sequencer: owns the GPR and single CRF write port after MEM/WB.
// A CRF pair write to two distinct registers is split over two cycles, stalling
// the pipeline for exactly one bubble. Writes to GPR zero are suppressed.
// Optional: define WB_SEQ_PERF_EN to add bubble_cnt / pair_cnt performance counters.
module wb_port_sequencer
  import wb_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GPR_AW = DEF_GPR_AW,
  parameter int CRF_AW = DEF_CRF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_port_sequencer_if.slave   bus,
  output wb_seq_state_t        state_dbg_o
`ifdef WB_SEQ_PERF_EN
  ,
  output logic [31:0]          bubble_cnt,
  output logic [31:0]          pair_cnt
`endif
);

  wb_seq_state_t     state_q;
  logic              gpr_we_q;
  logic [GPR_AW-1:0] gpr_waddr_q;
  logic [DATA_W-1:0] gpr_wdata_q;
  logic              crf_we_q;
  logic [CRF_AW-1:0] crf_waddr_q;
  logic [DATA_W-1:0] crf_wdata_q;
  logic [CRF_AW-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;

  logic accept;
  logic pair_split;
  logic pair_same;

  // Ready is a pure function of state so it never forms a loop with in_valid.
  assign bus.in_ready = (state_q == IDLE);
  assign accept       = bus.in_valid & bus.in_ready;

  // Pair with distinct targets needs two CRF cycles; same target collapses to last-wins.
  assign pair_split = bus.crf_we_in & bus.crf_pair_in & (bus.crf_addr1_in != bus.crf_addr2_in);
  assign pair_same  = bus.crf_we_in & bus.crf_pair_in & (bus.crf_addr1_in == bus.crf_addr2_in);

  // Sequencer FSM with registered write-port outputs and second-write hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      crf_we_q    <= 1'b0;
      crf_waddr_q <= '0;
      crf_wdata_q <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            gpr_we_q    <= bus.gpr_we_in & (bus.gpr_addr_in != GPR_AW'(GPR_ZERO));
            gpr_waddr_q <= bus.gpr_addr_in;
            gpr_wdata_q <= bus.gpr_data_in;
            crf_we_q    <= bus.crf_we_in;
            if (pair_same) begin
              crf_waddr_q <= bus.crf_addr2_in;
              crf_wdata_q <= bus.crf_data2_in;
            end else begin
              crf_waddr_q <= bus.crf_addr1_in;
              crf_wdata_q <= bus.crf_data1_in;
            end
            if (pair_split) begin
              hold_addr_q <= bus.crf_addr2_in;
              hold_data_q <= bus.crf_data2_in;
              state_q     <= PEND2;
            end
          end else begin
            gpr_we_q <= 1'b0;
            crf_we_q <= 1'b0;
          end
        end
        PEND2: begin
          gpr_we_q    <= 1'b0;
          crf_we_q    <= 1'b1;
          crf_waddr_q <= hold_addr_q;
          crf_wdata_q <= hold_data_q;
          state_q     <= IDLE;
        end
        default: begin
          gpr_we_q <= 1'b0;
          crf_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gpr_we    = gpr_we_q;
  assign bus.gpr_waddr = gpr_waddr_q;
  assign bus.gpr_wdata = gpr_wdata_q;
  assign bus.crf_we    = crf_we_q;
  assign bus.crf_waddr = crf_waddr_q;
  assign bus.crf_wdata = crf_wdata_q;
  assign state_dbg_o   = state_q;

`ifdef WB_SEQ_PERF_EN
  wb_seq_perf_cnt u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (state_q == PEND2),
    .clear_i (1'b0),
    .cnt_o   (bubble_cnt)
  );

  wb_seq_perf_cnt u_pair_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept & pair_split),
    .clear_i (1'b0),
    .cnt_o   (pair_cnt)
  );
`endif

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Self-checking bench for wb_port_sequencer: directed cases plus random ops against
// a transaction-level model of expected GPR/CRF writes and their arrival cycles.
module tb_wb_port_sequencer;
  import wb_seq_pkg::*;

  localparam int DW = 32;
  localparam int GA = 5;
  localparam int CA = 4;
  localparam int GW = 32 + GA + DW;
  localparam int CW = 32 + CA + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wb_port_sequencer_if #(.DATA_W(DW), .GPR_AW(GA), .CRF_AW(CA)) bus ();
  wb_seq_state_t state_dbg;
`ifdef WB_SEQ_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] pair_cnt;
`endif

  wb_port_sequencer #(.DATA_W(DW), .GPR_AW(GA), .CRF_AW(CA)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
`ifdef WB_SEQ_PERF_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .pair_cnt    (pair_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  // Entries: {due cycle, address, data}.
  logic [GW-1:0] gpr_exp_q[$];
  logic [CW-1:0] crf_exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  pend_m = 1'b0;   // model: a split pair's second write is outstanding
  int  pair_m = 0;
  int  bubble_m = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed strobe must match the oldest expected write, on its due cycle.
  logic [GW-1:0] g_pop;
  logic [CW-1:0] c_pop;
  always @(negedge clk) begin
    if (bus.gpr_we === 1'b1) begin
      if (gpr_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL gpr_unexpected: got addr %0h data %0h expected no write (cycle %0d)",
                 bus.gpr_waddr, bus.gpr_wdata, cyc);
      end else begin
        g_pop = gpr_exp_q.pop_front();
        chk("gpr_write", 128'({32'(cyc), bus.gpr_waddr, bus.gpr_wdata}), 128'(g_pop));
      end
    end
    while (gpr_exp_q.size() > 0 && int'(gpr_exp_q[0][GW-1 -: 32]) < cyc) begin
      g_pop = gpr_exp_q.pop_front();
      checks++; errors++;
      $display("FAIL gpr_missed: got no write expected %0h (cycle %0d)", g_pop, cyc);
    end
    if (bus.crf_we === 1'b1) begin
      if (crf_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL crf_unexpected: got addr %0h data %0h expected no write (cycle %0d)",
                 bus.crf_waddr, bus.crf_wdata, cyc);
      end else begin
        c_pop = crf_exp_q.pop_front();
        chk("crf_write", 128'({32'(cyc), bus.crf_waddr, bus.crf_wdata}), 128'(c_pop));
      end
    end
    while (crf_exp_q.size() > 0 && int'(crf_exp_q[0][CW-1 -: 32]) < cyc) begin
      c_pop = crf_exp_q.pop_front();
      checks++; errors++;
      $display("FAIL crf_missed: got no write expected %0h (cycle %0d)", c_pop, cyc);
    end
  end

  // ---------------- driver ----------------
  // Presents one op for one cycle; the model decides acceptance from its own state.
  task automatic drive(input bit v, input bit gwe, input logic [GA-1:0] ga, input logic [DW-1:0] gd,
                       input bit cwe, input bit cp, input logic [CA-1:0] a1, input logic [CA-1:0] a2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    @(negedge clk);
    chk("in_ready", 128'(bus.in_ready), 128'(!pend_m));
    bus.in_valid     = v;
    bus.gpr_we_in    = gwe;
    bus.gpr_addr_in  = ga;
    bus.gpr_data_in  = gd;
    bus.crf_we_in    = cwe;
    bus.crf_pair_in  = cp;
    bus.crf_addr1_in = a1;
    bus.crf_addr2_in = a2;
    bus.crf_data1_in = d1;
    bus.crf_data2_in = d2;
    if (pend_m) begin
      pend_m = 1'b0;
      bubble_m++;
    end else if (v) begin
      if (gwe && ga != 0) gpr_exp_q.push_back({32'(cyc + 1), ga, gd});
      if (cwe) begin
        if (cp && a1 != a2) begin
          crf_exp_q.push_back({32'(cyc + 1), a1, d1});
          crf_exp_q.push_back({32'(cyc + 2), a2, d2});
          pend_m = 1'b1;
          pair_m++;
        end else if (cp) begin
          crf_exp_q.push_back({32'(cyc + 1), a2, d2});
        end else begin
          crf_exp_q.push_back({32'(cyc + 1), a1, d1});
        end
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic drive_random();
    logic [GA-1:0] ga;
    logic [CA-1:0] a1, a2;
    ga = ($urandom_range(0, 3) == 0) ? '0 : GA'($urandom_range(1, 31));
    a1 = CA'($urandom_range(0, 15));
    a2 = ($urandom_range(0, 3) == 0) ? a1 : CA'($urandom_range(0, 15));
    drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ga, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, a2, $urandom, $urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_gpr_we"},    128'(bus.gpr_we),    128'(0));
    chk({tag, "_gpr_waddr"}, 128'(bus.gpr_waddr), 128'(0));
    chk({tag, "_gpr_wdata"}, 128'(bus.gpr_wdata), 128'(0));
    chk({tag, "_crf_we"},    128'(bus.crf_we),    128'(0));
    chk({tag, "_crf_waddr"}, 128'(bus.crf_waddr), 128'(0));
    chk({tag, "_crf_wdata"}, 128'(bus.crf_wdata), 128'(0));
    chk({tag, "_state"},     128'(state_dbg),     128'(IDLE));
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0; bus.gpr_we_in = 1'b0; bus.gpr_addr_in = '0; bus.gpr_data_in = '0;
    bus.crf_we_in = 1'b0; bus.crf_pair_in = 1'b0; bus.crf_addr1_in = '0; bus.crf_addr2_in = '0;
    bus.crf_data1_in = '0; bus.crf_data2_in = '0;

    // Reset with a valid op presented: nothing may be accepted.
    repeat (2) @(posedge clk);
    bus.in_valid = 1'b1; bus.gpr_we_in = 1'b1; bus.gpr_addr_in = 5'd3; bus.crf_we_in = 1'b1;
    @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Scalar write three cycles in a row, no bubbles.
    repeat (3) drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, '0, '0);
    idle();

    // Split pair: two CRF writes, one stall cycle; junk during the stall is ignored.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 4'd3, 4'd7, 32'h11, 32'h22);
    drive(1'b1, 1'b1, 5'd9, 32'hBAD, 1'b1, 1'b0, 4'd1, 4'd2, 32'hBAD1, 32'hBAD2);
    idle();

    // Same-address pair: single last-wins write, no stall.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 4'd9, 4'd9, 32'hA, 32'hB);
    idle();

    // GPR zero suppressed while the CRF write of the same op still happens.
    drive(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b0, 4'd6, 4'd0, 32'h55, 32'h66);
    // Pair flag without CRF enable: no stall, no CRF write.
    drive(1'b1, 1'b1, 5'd4, 32'h77, 1'b0, 1'b1, 4'd2, 4'd3, 32'h88, 32'h99);
    idle();

    // Four back-to-back pairs: eight CRF writes, four bubbles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, GA'(i + 1), 32'(i), 1'b1, 1'b1, CA'(2 * i), CA'(2 * i + 1),
            32'(16 * i), 32'(16 * i + 1));
      drive(1'b1, 1'b1, GA'(i + 1), 32'(i), 1'b1, 1'b1, CA'(2 * i), CA'(2 * i + 1),
            32'(16 * i), 32'(16 * i + 1));
    end
    idle();
`ifdef WB_SEQ_PERF_EN
    chk("pair_cnt_burst",   128'(pair_cnt),   128'(pair_m));
    chk("bubble_cnt_burst", 128'(bubble_cnt), 128'(bubble_m));
`endif

    // Reset during PEND2: pending second write dropped.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 4'd10, 4'd11, 32'hC0, 32'hC1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_pend2");
    crf_exp_q.delete();
    gpr_exp_q.delete();
    pend_m = 1'b0;
    pair_m = 0;
    bubble_m = 0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    chk("rst_release_state", 128'(state_dbg), 128'(IDLE));
    repeat (2) idle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) drive_random();
    repeat (4) idle();

    chk("gpr_queue_drained", 128'(gpr_exp_q.size()), 128'(0));
    chk("crf_queue_drained", 128'(crf_exp_q.size()), 128'(0));
`ifdef WB_SEQ_PERF_EN
    chk("pair_cnt_final",   128'(pair_cnt),   128'(pair_m));
    chk("bubble_cnt_final", 128'(bubble_cnt), 128'(bubble_m));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
